// File: rtl/r0_pkg.sv
`default_nettype none
// ============================================================================
// Module  : r0_pkg
// Purpose : Shared definitions for the r0 multiplexer/demultiplexer pair:
//           routing codes, the demultiplexer FSM state type, default width
//           and a small routing helper.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package r0_pkg;

  // Default data width of the r0 result bus.
  localparam int R0_WIDTH_DEFAULT = 8;

  // Routing codes; the multiplexer uses the same encoding on the send side.
  localparam logic [1:0] R0_TO_OUT1     = 2'd0;  // one beat -> Output1
  localparam logic [1:0] R0_TO_OUT2     = 2'd1;  // one beat -> Output2
  localparam logic [1:0] R0_TO_BOTH_SEQ = 2'd2;  // two beats, Output1 then Output2
  localparam logic [1:0] R0_BROADCAST   = 2'd3;  // one beat -> both outputs

  // Demultiplexer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV1 = 2'd1,
    ST_RECV2 = 2'd2,
    ST_DONE  = 2'd3
  } r0_state_e;

  // True when the routing code needs a second beat after the first.
  function automatic logic r0_is_two_beat(input logic [1:0] code);
    return (code == R0_TO_BOTH_SEQ);
  endfunction

endpackage : r0_pkg
`default_nettype wire

// File: rtl/r0_demux_timer.sv
`default_nettype none
// ============================================================================
// Module  : r0_demux_timer
// Purpose : Per-beat idle timeout down-counter for r0_demultiplexer.
//           'load' re-arms the counter to TIMEOUT-1; each 'tick' counts one
//           idle cycle; 'expire' is high on the tick that completes the
//           TIMEOUT-th consecutive idle cycle.
// Ports   : clk    - system clock
//           reset  - asynchronous active-high reset
//           load   - re-arm request (outside a wait, or a beat accepted)
//           tick   - one idle cycle while waiting for a beat
//           expire - timeout reached on this tick (combinational)
// Config  : exists only when R0_DEMUX_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`ifdef R0_DEMUX_TIMEOUT_EN
module r0_demux_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expire
);

  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter holds at zero; the zero value plus a tick is the expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = tick && !load && (cnt_q == '0);

endmodule : r0_demux_timer
`endif
`default_nettype wire

// File: rtl/r0_demultiplexer.sv
`default_nettype none
// ============================================================================
// Module  : r0_demultiplexer
// Purpose : Collects beats from the shared result bus and steers them into
//           Output1/Output2 according to a 2-bit routing code captured at the
//           start of a transfer. ready pulses for one cycle on completion.
// Ports   : clk         - system clock
//           reset       - asynchronous active-high reset
//           en          - start request, sampled only in IDLE
//           state       - routing code, captured when a transfer starts
//           data_in     - beat data, valid when valid_in=1
//           valid_in    - beat strobe, honoured only in RECV1/RECV2
//           Output1     - destination register 1
//           Output2     - destination register 2
//           busy        - high in RECV1, RECV2 and DONE
//           ready       - one-cycle completion pulse
//           timeout_err - sticky timeout flag (timeout builds only)
// Config  : R0_DEMUX_TIMEOUT_EN adds the per-beat idle timeout, the TIMEOUT
//           parameter and the timeout_err port. Without it the block waits
//           indefinitely for each beat.
// Revision: 1.0 - initial release
// ============================================================================
module r0_demultiplexer
  import r0_pkg::*;
#(
  parameter int WIDTH   = R0_WIDTH_DEFAULT
`ifdef R0_DEMUX_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] Output1,
  output logic [WIDTH-1:0] Output2,
  output logic             busy,
  output logic             ready
`ifdef R0_DEMUX_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  r0_state_e        fsm_q,   fsm_d;
  logic [1:0]       st_q,    st_d;
  logic [WIDTH-1:0] out1_q,  out1_d;
  logic [WIDTH-1:0] out2_q,  out2_d;
  logic             busy_q,  busy_d;
  logic             ready_q, ready_d;
  logic             timeout_hit;

  // --------------------------------------------------------------------------
  // Optional per-beat idle timeout
  // --------------------------------------------------------------------------
`ifdef R0_DEMUX_TIMEOUT_EN
  logic in_recv;
  logic timer_load;
  logic timer_tick;
  logic err_q, err_d;

  assign in_recv    = (fsm_q == ST_RECV1) || (fsm_q == ST_RECV2);
  // Re-arm whenever not waiting, and on every accepted beat.
  assign timer_load = !in_recv || valid_in;
  assign timer_tick = in_recv && !valid_in;

  r0_demux_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .tick   (timer_tick),
    .expire (timeout_hit)
  );

  // Sticky until the next accepted start request.
  always_comb begin
    err_d = err_q;
    if ((fsm_q == ST_IDLE) && en) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Transfer FSM and output registers
  // --------------------------------------------------------------------------
  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    out1_d = out1_q;
    out2_d = out2_q;

    case (fsm_q)
      ST_IDLE: begin
        // Beat data in the start cycle is deliberately not looked at.
        if (en) begin
          st_d  = state;
          fsm_d = ST_RECV1;
        end
      end

      ST_RECV1: begin
        if (valid_in) begin
          case (st_q)
            R0_TO_OUT1:     out1_d = data_in;
            R0_TO_OUT2:     out2_d = data_in;
            R0_TO_BOTH_SEQ: out1_d = data_in;
            R0_BROADCAST: begin
              out1_d = data_in;
              out2_d = data_in;
            end
            default: ;
          endcase
          fsm_d = r0_is_two_beat(st_q) ? ST_RECV2 : ST_DONE;
        end else if (timeout_hit) begin
          fsm_d = ST_IDLE;
        end
      end

      ST_RECV2: begin
        if (valid_in) begin
          out2_d = data_in;
          fsm_d  = ST_DONE;
        end else if (timeout_hit) begin
          fsm_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        // Always returns to IDLE; en here cannot start a new transfer.
        fsm_d = ST_IDLE;
      end

      default: fsm_d = ST_IDLE;
    endcase

    // Status flags are decoded from the next state so that they are
    // registered alongside it.
    busy_d  = (fsm_d != ST_IDLE);
    ready_d = (fsm_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      st_q    <= 2'd0;
      out1_q  <= '0;
      out2_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign Output1 = out1_q;
  assign Output2 = out2_q;
  assign busy    = busy_q;
  assign ready   = ready_q;

endmodule : r0_demultiplexer
`default_nettype wire
